// File: rtl/debug_pkg.sv
// Shared command codes and FSM state encoding for the debug unit.
package debug_pkg;

  localparam logic [7:0] CMD_LOAD  = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_RUN   = 8'h43;  // 'C'
  localparam logic [7:0] CMD_STEP  = 8'h53;  // 'S'
  localparam logic [7:0] CMD_RESET = 8'h52;  // 'R'
  localparam logic [7:0] ACK_BYTE  = 8'h06;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_CNT,
    LOAD_BYTE,
    LOAD_WR,
    RUN,
    STEP,
    TX_BYTE,
    TX_WAIT
  } state_t;

endpackage

// File: rtl/debug_tx_serializer.sv
// Sends a latched 32-bit word as 1 or 4 UART bytes, MSB first, honouring tx_busy.
module debug_tx_serializer
  import debug_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] word,
  input  logic [2:0]  byte_cnt,
  input  logic        start,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        done
);

  state_t      state;
  logic [31:0] shreg;
  logic [2:0]  left;
  logic        skip;

  // Last byte accepted by the UART: finished this cycle.
  assign done = (state == TX_WAIT) && !skip && !tx_busy && (left == 3'd1);

  // Byte sequencer: wait idle, pulse tx_start, skip one cycle, wait idle again.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      shreg    <= '0;
      left     <= '0;
      skip     <= 1'b0;
      tx_data  <= '0;
      tx_start <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // A single byte is taken from the low lane and moved to the top.
            shreg <= (byte_cnt == 3'd1) ? {word[7:0], 24'h000000} : word;
            left  <= (byte_cnt == 3'd1) ? 3'd1 : 3'd4;
            state <= TX_BYTE;
          end
        end
        TX_BYTE: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= shreg[31:24];
            shreg    <= {shreg[23:0], 8'h00};
            skip     <= 1'b1;
            state    <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          if (skip) begin
            skip <= 1'b0;
          end else if (!tx_busy) begin
            left  <= left - 3'd1;
            state <= (left == 3'd1) ? IDLE : TX_BYTE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/debug_unit.sv
// UART-driven debug controller: program load, run, single-step, CPU reset.
module debug_unit
  import debug_pkg::*;
#(
  parameter int IMEM_AW = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  input  logic               tx_busy,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               cpu_enable,
  output logic               cpu_reset,
  input  logic               cpu_halt,
  input  logic [31:0]        cpu_pc
);

  state_t             state;
  logic [7:0]         words_left;
  logic [1:0]         byte_idx;
  logic [IMEM_AW-1:0] word_idx;
  logic [23:0]        asm_buf;
  logic               stepped;
  logic               ser_start;
  logic [31:0]        ser_word;
  logic [2:0]         ser_cnt;
  logic               ser_done;

  // Halt is checked in the same cycle so a halted CPU never gets an extra advance.
  assign cpu_enable = ((state == RUN) && !cpu_halt) || ((state == STEP) && !stepped);

  // Command decoder, loader and run/step control.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      words_left <= '0;
      byte_idx   <= '0;
      word_idx   <= '0;
      asm_buf    <= '0;
      stepped    <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      ser_start  <= 1'b0;
      ser_word   <= '0;
      ser_cnt    <= '0;
    end else begin
      imem_we   <= 1'b0;
      ser_start <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            case (rx_data)
              CMD_LOAD: state <= LOAD_CNT;
              CMD_RUN:  state <= RUN;
              CMD_STEP: state <= STEP;
              CMD_RESET: begin
                cpu_reset <= 1'b1;
                ser_word  <= {24'h000000, ACK_BYTE};
                ser_cnt   <= 3'd1;
                ser_start <= 1'b1;
                state     <= TX_BYTE;
              end
              default: state <= IDLE;
            endcase
          end
        end
        LOAD_CNT: begin
          if (rx_valid) begin
            if (rx_data == 8'h00) begin
              state <= IDLE;
            end else begin
              words_left <= rx_data;
              word_idx   <= '0;
              byte_idx   <= '0;
              cpu_reset  <= 1'b1;
              state      <= LOAD_BYTE;
            end
          end
        end
        LOAD_BYTE: begin
          if (rx_valid) begin
            asm_buf  <= {asm_buf[15:0], rx_data};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_idx;
              imem_wdata <= {asm_buf, rx_data};
              state      <= LOAD_WR;
            end
          end
        end
        LOAD_WR: begin
          word_idx   <= word_idx + 1'b1;
          words_left <= words_left - 8'd1;
          if (words_left == 8'd1) begin
            ser_word  <= {24'h000000, ACK_BYTE};
            ser_cnt   <= 3'd1;
            ser_start <= 1'b1;
            state     <= TX_BYTE;
          end else begin
            state <= LOAD_BYTE;
          end
        end
        RUN: begin
          if (cpu_halt) begin
            ser_word  <= cpu_pc;
            ser_cnt   <= 3'd4;
            ser_start <= 1'b1;
            state     <= TX_BYTE;
          end
        end
        STEP: begin
          // First cycle advances the CPU; second cycle captures the updated pc.
          if (!stepped) begin
            stepped <= 1'b1;
          end else begin
            stepped   <= 1'b0;
            ser_word  <= cpu_pc;
            ser_cnt   <= 3'd4;
            ser_start <= 1'b1;
            state     <= TX_BYTE;
          end
        end
        TX_BYTE: begin
          // Releases the one-cycle 'R' pulse and the end-of-load hold alike.
          cpu_reset <= 1'b0;
          if (ser_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  debug_tx_serializer u_tx (
    .clk      (clk),
    .reset    (reset),
    .word     (ser_word),
    .byte_cnt (ser_cnt),
    .start    (ser_start),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .done     (ser_done)
  );

endmodule

// File: tb/tb_debug_unit.sv
`timescale 1ns/1ps
module tb_debug_unit;
  import debug_pkg::*;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          tx_busy;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_enable;
  logic          cpu_reset;
  logic          cpu_halt;
  logic [31:0]   cpu_pc;

  // Scoreboard queues
  logic [7:0]       exp_tx[$];
  logic [AW+31:0]   exp_wr[$];

  int checks = 0;
  int errors = 0;
  int wr_count = 0;

  // CPU / UART models
  logic [31:0] pc = '0;
  int en_count = 0;
  int en_base = 0;
  int busy_cnt = 0;
  int busy_len = 3;
  logic force_halt = 1'b0;
  logic halt_mode = 1'b0;
  int halt_limit = 0;

  debug_unit #(.IMEM_AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_busy    (tx_busy),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_enable (cpu_enable),
    .cpu_reset  (cpu_reset),
    .cpu_halt   (cpu_halt),
    .cpu_pc     (cpu_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  assign cpu_pc   = pc;
  assign tx_busy  = (busy_cnt != 0);
  assign cpu_halt = force_halt || (halt_mode && ((en_count - en_base) >= halt_limit));

  always @(posedge clk) begin
    if (cpu_reset) pc <= '0;
    else if (cpu_enable) pc <= pc + 32'd4;
    if (cpu_enable) en_count <= en_count + 1;
    if (tx_start) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  // Output monitor: pops scoreboard entries as the DUT produces them.
  always @(negedge clk) begin
    if (tx_start) begin
      check("tx_start_while_busy", 64'(tx_busy), 64'd0);
      check("tx_expected", 64'(exp_tx.size() > 0), 64'd1);
      if (exp_tx.size() > 0) check("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
    end
    if (imem_we) begin
      wr_count++;
      check("wr_expected", 64'(exp_wr.size() > 0), 64'd1);
      if (exp_wr.size() > 0) check("imem_write", 64'({imem_addr, imem_wdata}), 64'(exp_wr.pop_front()));
    end
    if (tx_start || imem_we || cpu_enable)
      check("exclusive", 64'(int'(tx_start) + int'(imem_we) + int'(cpu_enable)), 64'd1);
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic push_pc(input logic [31:0] v);
    exp_tx.push_back(v[31:24]);
    exp_tx.push_back(v[23:16]);
    exp_tx.push_back(v[15:8]);
    exp_tx.push_back(v[7:0]);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((exp_tx.size() != 0 || dut.state != IDLE) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(n < 2000), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_tx_start", 64'(tx_start), 64'd0);
    check("rst_imem_we", 64'(imem_we), 64'd0);
    check("rst_cpu_enable", 64'(cpu_enable), 64'd0);
    check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    check("rst_imem_addr", 64'(imem_addr), 64'd0);
    check("rst_imem_wdata", 64'(imem_wdata), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("cpu_reset_held", 64'(cpu_reset), 64'd1);

    // Two-word load
    exp_wr.push_back({8'h00, 32'hDEADBEEF});
    exp_wr.push_back({8'h01, 32'h00000001});
    exp_tx.push_back(ACK_BYTE);
    send_byte(CMD_LOAD);
    send_byte(8'h02);
    send_byte(8'hDE);
    check("cpu_reset_in_load", 64'(cpu_reset), 64'd1);
    send_byte(8'hAD);
    send_byte(8'hBE);
    send_byte(8'hEF);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h01);
    wait_done("load_timeout");
    check("load_wr_count", 64'(wr_count), 64'd2);
    check("load_cpu_reset", 64'(cpu_reset), 64'd0);

    // Zero-length load
    send_byte(CMD_LOAD);
    send_byte(8'h00);
    repeat (10) @(negedge clk);
    check("load0_state", 64'(dut.state), 64'(IDLE));
    check("load0_wr_count", 64'(wr_count), 64'd2);
    check("load0_cpu_reset", 64'(cpu_reset), 64'd0);

    // Single step while halt is high
    force_halt = 1'b1;
    en_base = en_count;
    push_pc(32'h00000004);
    send_byte(CMD_STEP);
    wait_done("step_timeout");
    check("step_enables", 64'(en_count - en_base), 64'd1);
    force_halt = 1'b0;

    // CPU reset command
    exp_tx.push_back(ACK_BYTE);
    send_byte(CMD_RESET);
    wait_done("rcmd_timeout");
    check("rcmd_cpu_reset", 64'(cpu_reset), 64'd0);
    check("rcmd_pc_cleared", 64'(cpu_pc), 64'd0);

    // Run to halt, with bytes arriving during the run
    en_base = en_count;
    halt_limit = 7;
    halt_mode = 1'b1;
    push_pc(32'h0000001C);
    send_byte(CMD_RUN);
    send_byte(8'h41);
    send_byte(CMD_LOAD);
    wait_done("run_timeout");
    check("run_enables", 64'(en_count - en_base), 64'd7);
    check("run_state_idle", 64'(dut.state), 64'(IDLE));
    halt_mode = 1'b0;

    // Halt already high on entry, slow UART
    exp_tx.push_back(ACK_BYTE);
    send_byte(CMD_RESET);
    wait_done("rcmd2_timeout");
    busy_len = 20;
    force_halt = 1'b1;
    en_base = en_count;
    push_pc(32'h00000000);
    send_byte(CMD_RUN);
    wait_done("halted_run_timeout");
    check("halted_run_enables", 64'(en_count - en_base), 64'd0);
    force_halt = 1'b0;
    busy_len = 3;

    // Reset in the middle of a load
    send_byte(CMD_LOAD);
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_imem_we", 64'(imem_we), 64'd0);
    check("midrst_cpu_reset", 64'(cpu_reset), 64'd1);
    check("midrst_state", 64'(dut.state), 64'(IDLE));
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_wr_count", 64'(wr_count), 64'd2);

    // Fresh load restarts at address 0
    exp_wr.push_back({8'h00, 32'h12345678});
    exp_tx.push_back(ACK_BYTE);
    send_byte(CMD_LOAD);
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    wait_done("reload_timeout");
    check("reload_wr_count", 64'(wr_count), 64'd3);
    check("final_queues_empty", 64'(exp_tx.size() + exp_wr.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debug_unit.md
DEBUG_UNIT -- requirements
Module: debug_unit

Interface
REQ-001 The block SHALL have parameter IMEM_AW, default 8, meaning the instruction-memory word-address width.
REQ-002 The block SHALL have port clk  input  1  the single system clock; all logic on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port rx_data  input  8  received UART byte.
REQ-005 The block SHALL have port rx_valid  input  1  one-cycle strobe; rx_data valid this cycle.
REQ-006 The block SHALL have port tx_busy  input  1  UART transmitter busy; rises the cycle after tx_start.
REQ-007 The block SHALL have port tx_data  output  8  byte to transmit; stable while tx_start is high.
REQ-008 The block SHALL have port tx_start  output  1  one-cycle transmit request.
REQ-009 The block SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-010 The block SHALL have port imem_addr  output  IMEM_AW  instruction-memory word address.
REQ-011 The block SHALL have port imem_wdata  output  32  instruction word.
REQ-012 The block SHALL have port cpu_enable  output  1  processor clock-enable; one pipeline advance per high cycle.
REQ-013 The block SHALL have port cpu_reset  output  1  synchronous reset to the processor, active-high.
REQ-014 The block SHALL have port cpu_halt  input  1  processor fetched HALT.
REQ-015 The block SHALL have port cpu_pc  input  32  processor program counter.

Function
REQ-016 FSM states: IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WR, RUN, STEP, TX_BYTE, TX_WAIT.
REQ-017 In IDLE, rx_valid with 0x4C ('L') -> LOAD_CNT; 0x43 ('C') -> RUN; 0x53 ('S') -> STEP; 0x52 ('R') -> cpu_reset high one cycle, then send ACK 0x06; other bytes ignored, stay IDLE.
REQ-018 In LOAD_CNT, the next rx byte N sets the word count; N=0 -> IDLE with no write and no ACK.
REQ-019 Load: cpu_reset held high; bytes assembled MSB first; after the 4th byte, LOAD_WR asserts imem_we for exactly one cycle with imem_addr = word index (0 upward) and imem_wdata = assembled word.
REQ-020 After the Nth write, cpu_reset deasserts and the block sends ACK 0x06, then IDLE; the word index wraps modulo 2^IMEM_AW.
REQ-021 RUN: cpu_halt is sampled each cycle before enable; while low, cpu_enable=1; the first cycle it is high, cpu_enable=0 and the block sends cpu_pc; halt already high on entry -> zero enable cycles.
REQ-022 STEP: cpu_enable high for exactly one cycle regardless of cpu_halt, then the block sends cpu_pc as sampled the cycle after the enable.
REQ-023 PC send: 4 bytes MSB first, pc latched at entry; the TX sub-sequence is shared with ACK (1 byte).
REQ-024 Per byte: TX_BYTE waits for tx_busy=0, pulses tx_start one cycle; TX_WAIT skips one cycle, then waits for tx_busy=0; after the last byte -> IDLE.
REQ-025 rx_valid outside IDLE, LOAD_CNT and LOAD_BYTE is ignored and not buffered.
REQ-026 imem_we, tx_start and cpu_enable are never high in the same cycle.

Reset
REQ-027 Reset assertion SHALL asynchronously force state IDLE, imem_we=0, imem_addr=0, imem_wdata=0, tx_start=0, tx_data=0, cpu_enable=0, cpu_reset=1, and clear the counters; a reset mid-load or mid-send abandons the operation with no partial write or byte.
REQ-028 cpu_reset stays 1 after reset until the first completed load or 'R' command.

Structure
REQ-029 Package debug_pkg SHALL hold the command codes (L/C/S/R), ACK 0x06 and the FSM state enum.
REQ-030 Byte serialization (REQ-023, REQ-024) SHALL be sub-module debug_tx_serializer, with inputs a 32-bit word, a byte count of 1 or 4 and a start pulse, and a done output.

Verification
REQ-031 Reset, then 'L',0x02,DE,AD,BE,EF,00,00,00,01 -> writes addr0=0xDEADBEEF, addr1=0x00000001, one imem_we each, then tx 0x06 and cpu_reset=0.
REQ-032 'L',0x00 -> no imem_we, no tx, FSM back in IDLE.
REQ-033 'S' with cpu_pc=0x00000004 after the step -> exactly 1 cpu_enable cycle, tx 00,00,00,04.
REQ-034 'C', cpu_halt raised after 7 enable cycles, cpu_pc=0x1C -> exactly 7 cpu_enable cycles, tx 00,00,00,1C.
REQ-035 tx_busy held high 20 cycles per byte during a PC send -> no tx_start while busy, 4 bytes in order; reset after the 2nd word byte of a load -> no imem_we, IDLE, cpu_reset=1.
REQ-036 Bytes 0x41 and 'L' sent during RUN -> ignored, run continues unaffected.
